// File: rtl/rgb_seq_pkg.sv
// Shared types and word-packing helpers for the RGB byte-to-pixel write sequencer.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    ST_B = 2'd0,
    ST_G = 2'd1,
    ST_R = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  // Write side 1 carries blue plus the top five green bits.
  function automatic logic [15:0] pack_data1(input pixel_t p);
    return {1'b0, p.g[7:3], p.b, 2'b00};
  endfunction

  // Write side 2 carries red plus the low three green bits.
  function automatic logic [15:0] pack_data2(input pixel_t p);
    return {1'b0, p.g[2:0], 2'b00, p.r, 2'b00};
  endfunction

endpackage

// File: rtl/rgb_write_sequencer_pix_skid_fifo.sv
// Two-entry pixel buffer that absorbs write-FIFO backpressure; head is valid when not empty.
module pix_skid_fifo
  import rgb_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  pixel_t push_data,
  output pixel_t head,
  output logic   full,
  output logic   empty
);

  pixel_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so a push into a full buffer still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/rgb_write_sequencer.sv
// Assembles B,G,R bytes into pixels and issues paired 16-bit SDRAM port writes with frame tracking.
// Write handshake: a word transfers on every cycle where oWR is high; oWR never rises while iWR_FULL is high.
module rgb_write_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int PIXELS  = 307200,
  parameter int TIMEOUT = 50000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iByte_valid,
  input  logic [7:0]  iByte,
  input  logic        iResync,
  input  logic        iWR_FULL,
  output logic        oWR,
  output logic [15:0] oWR_DATA1,
  output logic [15:0] oWR_DATA2,
  output logic        oWR_LOAD,
  output logic        oFrame_done,
  output logic [15:0] oFrame_cnt,
  output logic [19:0] oPix_idx,
  output logic [7:0]  oDrop_cnt,
  output logic        oTimeout,
  output state_e      dbg_state
);

  localparam int              TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [19:0]     PIX_LAST = 20'(PIXELS - 1);

  state_e        state_q, state_d;
  logic [7:0]    b_q, g_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_evt;
  logic          push;
  logic          drop;
  logic          boot_q;
  logic          fifo_full, fifo_empty;
  pixel_t        head;
  pixel_t        new_pix;

  assign dbg_state = state_q;
  assign new_pix   = '{b: b_q, g: g_q, r: iByte};

  // Resync takes precedence over bytes and the timeout; a byte takes precedence over the timeout.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    tmo_evt = 1'b0;
    push    = 1'b0;
    if (iResync) begin
      state_d = ST_B;
      tmo_d   = '0;
    end else if (iByte_valid) begin
      tmo_d = '0;
      case (state_q)
        ST_B:    state_d = ST_G;
        ST_G:    state_d = ST_R;
        ST_R: begin
          state_d = ST_B;
          push    = 1'b1;
        end
        default: state_d = ST_B;
      endcase
    end else if (state_q != ST_B) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_B;
        tmo_d   = '0;
        tmo_evt = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  assign oWR       = ~fifo_empty & ~iWR_FULL & ~iResync & ~oWR_LOAD;
  assign drop      = push & fifo_full & ~oWR;
  assign oWR_DATA1 = pack_data1(head);
  assign oWR_DATA2 = pack_data2(head);

  pix_skid_fifo u_fifo (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .flush     (iResync),
    .push      (push),
    .pop       (oWR),
    .push_data (new_pix),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_B;
      b_q         <= '0;
      g_q         <= '0;
      tmo_q       <= '0;
      boot_q      <= 1'b1;
      oWR_LOAD    <= 1'b0;
      oFrame_done <= 1'b0;
      oTimeout    <= 1'b0;
      oFrame_cnt  <= '0;
      oPix_idx    <= '0;
      oDrop_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      boot_q      <= 1'b0;
      oWR_LOAD    <= iResync | boot_q;
      oTimeout    <= tmo_evt;
      oFrame_done <= 1'b0;
      if (!iResync && iByte_valid && state_q == ST_B) b_q <= iByte;
      if (!iResync && iByte_valid && state_q == ST_G) g_q <= iByte;
      if (drop && oDrop_cnt != 8'hFF) oDrop_cnt <= oDrop_cnt + 8'd1;
      if (iResync) begin
        oPix_idx <= '0;
      end else if (oWR) begin
        if (oPix_idx == PIX_LAST) begin
          oPix_idx    <= '0;
          oFrame_done <= 1'b1;
          oFrame_cnt  <= oFrame_cnt + 16'd1;
        end else begin
          oPix_idx <= oPix_idx + 20'd1;
        end
      end
    end
  end

endmodule
